// File: rtl/gmii_rx_frame_align_if.sv
// gmii_rx_frame_align_if
//   Byte stream produced by the GMII/MII receive framing stage and consumed by
//   the MAC receive datapath.
//   master modport : producer side (framing stage drives every signal)
//   slave modport  : consumer side
//   m_data  : payload byte, destination MAC onward
//   m_valid : one-cycle strobe per byte
//   m_first : first byte after the SFD (qualified by m_valid)
//   m_last  : final byte of the frame (qualified by m_valid)
//   m_error : rx_er seen in payload or odd nibble count; only on the last beat
interface gmii_rx_frame_align_if;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_first;
  logic       m_last;
  logic       m_error;

  modport master (output m_data, m_valid, m_first, m_last, m_error);
  modport slave  (input  m_data, m_valid, m_first, m_last, m_error);
endinterface

// File: rtl/gmii_rx_frame_align.sv
// gmii_rx_frame_align
//   Receive framing stage in the recovered RX clock domain. Strips preamble
//   and SFD from the raw GMII/MII receive bus, packs MII nibbles into bytes
//   (low nibble first), and emits a registered per-byte stream with
//   first/last/error markers. A one-byte hold register delays every byte by
//   one unit so the final byte can be tagged with m_last when dv falls.
//   clk               : recovered receive clock
//   rst               : synchronous active-high reset
//   gmii_rxd          : receive data; only [3:0] used in MII mode
//   gmii_rx_dv        : receive data valid
//   gmii_rx_er        : receive error
//   mii_select        : 1 = MII nibble mode, 0 = GMII byte mode (latched per frame)
//   m                 : output byte stream (master modport)
//   stat_bad_preamble : one-cycle pulse when a frame is dropped before its SFD
module gmii_rx_frame_align #(
  parameter int MAX_PREAMBLE = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             gmii_rxd,
  input  logic                   gmii_rx_dv,
  input  logic                   gmii_rx_er,
  input  logic                   mii_select,
  gmii_rx_frame_align_if.master  m,
  output logic                   stat_bad_preamble
);

  // Wide enough for the MII nibble count, which runs to twice the byte limit.
  localparam int               CNT_W   = $clog2(2 * MAX_PREAMBLE + 4);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PREAMBLE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PREAMBLE,
    S_DATA,
    S_DROP
  } state_t;

  state_t           state_q, state_d;
  logic             mii_q, mii_d;
  logic [CNT_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [7:0]       hold_q, hold_d;
  logic             hold_vld_q, hold_vld_d;
  logic [3:0]       nib_q, nib_d;
  logic             half_q, half_d;
  logic             err_q, err_d;
  logic             pend_first_q, pend_first_d;
  logic [7:0]       out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             out_first_q, out_first_d;
  logic             out_last_q, out_last_d;
  logic             out_error_q, out_error_d;
  logic             stat_q, stat_d;

  logic             unit_mii;
  logic             is_pre;
  logic             is_sfd;
  logic             too_long;
  logic [CNT_W-1:0] cnt_inc;
  logic             byte_done;
  logic [7:0]       byte_val;

  // In IDLE the mode comes straight from mii_select; once a frame has started
  // the latched copy is used so a mid-frame toggle has no effect.
  always_comb begin
    unit_mii = (state_q == S_IDLE) ? mii_select : mii_q;
    is_pre   = unit_mii ? (gmii_rxd[3:0] == 4'h5) : (gmii_rxd == 8'h55);
    is_sfd   = unit_mii ? (gmii_rxd[3:0] == 4'hD) : (gmii_rxd == 8'hD5);
    cnt_inc  = pre_cnt_q + 1'b1;
    // MII counts nibbles; the limit is expressed in nibble pairs.
    too_long = unit_mii ? ((cnt_inc >> 1) > MAX_CNT) : (cnt_inc > MAX_CNT);
  end

  always_comb begin
    state_d      = state_q;
    mii_d        = mii_q;
    pre_cnt_d    = pre_cnt_q;
    hold_d       = hold_q;
    hold_vld_d   = hold_vld_q;
    nib_d        = nib_q;
    half_d       = half_q;
    err_d        = err_q;
    pend_first_d = pend_first_q;
    out_data_d   = out_data_q;
    out_valid_d  = 1'b0;
    out_first_d  = 1'b0;
    out_last_d   = 1'b0;
    out_error_d  = 1'b0;
    stat_d       = 1'b0;
    byte_done    = 1'b0;
    byte_val     = gmii_rxd;

    case (state_q)
      S_IDLE: begin
        if (gmii_rx_dv) begin
          mii_d = mii_select;
          if (gmii_rx_er) begin
            state_d = S_DROP;
            stat_d  = 1'b1;
          end else if (is_pre) begin
            state_d   = S_PREAMBLE;
            pre_cnt_d = CNT_W'(1);
          end else if (is_sfd) begin
            state_d      = S_DATA;
            pend_first_d = 1'b1;
            hold_vld_d   = 1'b0;
            half_d       = 1'b0;
            err_d        = 1'b0;
          end else begin
            state_d = S_DROP;
            stat_d  = 1'b1;
          end
        end
      end

      S_PREAMBLE: begin
        if (!gmii_rx_dv) begin
          state_d = S_IDLE;
          stat_d  = 1'b1;
        end else if (gmii_rx_er) begin
          state_d = S_DROP;
          stat_d  = 1'b1;
        end else if (is_sfd) begin
          state_d      = S_DATA;
          pend_first_d = 1'b1;
          hold_vld_d   = 1'b0;
          half_d       = 1'b0;
          err_d        = 1'b0;
        end else if (is_pre && !too_long) begin
          pre_cnt_d = cnt_inc;
        end else begin
          state_d = S_DROP;
          stat_d  = 1'b1;
        end
      end

      S_DATA: begin
        if (gmii_rx_dv) begin
          err_d = err_q | gmii_rx_er;
          if (mii_q) begin
            if (half_q) begin
              byte_done = 1'b1;
              byte_val  = {gmii_rxd[3:0], nib_q};
              half_d    = 1'b0;
            end else begin
              nib_d  = gmii_rxd[3:0];
              half_d = 1'b1;
            end
          end else begin
            byte_done = 1'b1;
          end
          // A newly completed byte pushes the previous one out as a mid-frame beat.
          if (byte_done) begin
            if (hold_vld_q) begin
              out_valid_d  = 1'b1;
              out_data_d   = hold_q;
              out_first_d  = pend_first_q;
              pend_first_d = 1'b0;
            end
            hold_d     = byte_val;
            hold_vld_d = 1'b1;
          end
        end else begin
          // dv fell: flush the held byte as the last beat; a dangling nibble
          // is discarded but flags the frame as errored.
          if (hold_vld_q) begin
            out_valid_d = 1'b1;
            out_data_d  = hold_q;
            out_first_d = pend_first_q;
            out_last_d  = 1'b1;
            out_error_d = err_q | half_q;
          end
          state_d      = S_IDLE;
          hold_vld_d   = 1'b0;
          half_d       = 1'b0;
          err_d        = 1'b0;
          pend_first_d = 1'b0;
        end
      end

      S_DROP: begin
        if (!gmii_rx_dv) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      mii_q        <= 1'b0;
      pre_cnt_q    <= '0;
      hold_q       <= 8'h00;
      hold_vld_q   <= 1'b0;
      nib_q        <= 4'h0;
      half_q       <= 1'b0;
      err_q        <= 1'b0;
      pend_first_q <= 1'b0;
      out_data_q   <= 8'h00;
      out_valid_q  <= 1'b0;
      out_first_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_error_q  <= 1'b0;
      stat_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      mii_q        <= mii_d;
      pre_cnt_q    <= pre_cnt_d;
      hold_q       <= hold_d;
      hold_vld_q   <= hold_vld_d;
      nib_q        <= nib_d;
      half_q       <= half_d;
      err_q        <= err_d;
      pend_first_q <= pend_first_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      out_first_q  <= out_first_d;
      out_last_q   <= out_last_d;
      out_error_q  <= out_error_d;
      stat_q       <= stat_d;
    end
  end

  assign m.m_data          = out_data_q;
  assign m.m_valid         = out_valid_q;
  assign m.m_first         = out_first_q;
  assign m.m_last          = out_last_q;
  assign m.m_error         = out_error_q;
  assign stat_bad_preamble = stat_q;

endmodule

// File: tb/tb_gmii_rx_frame_align.sv
// tb_gmii_rx_frame_align
//   Scenario bench for gmii_rx_frame_align. Each scenario pushes the beats it
//   expects into a scoreboard queue before driving the bus; a monitor on the
//   falling edge pops and compares every emitted beat and counts stat pulses.
module tb_gmii_rx_frame_align;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] gmii_rxd;
  logic       gmii_rx_dv;
  logic       gmii_rx_er;
  logic       mii_select;
  logic       stat_bad_preamble;

  gmii_rx_frame_align_if mif ();

  gmii_rx_frame_align #(.MAX_PREAMBLE(15)) dut (
    .clk              (clk),
    .rst              (rst),
    .gmii_rxd         (gmii_rxd),
    .gmii_rx_dv       (gmii_rx_dv),
    .gmii_rx_er       (gmii_rx_er),
    .mii_select       (mii_select),
    .m                (mif),
    .stat_bad_preamble(stat_bad_preamble)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic       first;
    logic       last;
    logic       error;
  } beat_t;

  beat_t sb[$];
  int    n_compared = 0;
  int    n_mismatch = 0;
  int    cyc        = 0;
  int    stat_cnt   = 0;
  int    stat_cyc   = -1;
  int    first_cyc  = -1;
  int    last_cyc   = -1;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: every emitted beat must match the head of the queue.
  always @(negedge clk) begin
    beat_t got;
    beat_t exp;
    if (stat_bad_preamble) begin
      stat_cnt = stat_cnt + 1;
      stat_cyc = cyc;
    end
    if (mif.m_valid) begin
      got = {mif.m_data, mif.m_first, mif.m_last, mif.m_error};
      if (mif.m_first) first_cyc = cyc;
      if (mif.m_last)  last_cyc  = cyc;
      n_compared = n_compared + 1;
      if (sb.size() == 0) begin
        n_mismatch = n_mismatch + 1;
        $display("[TB] FAIL unexpected_beat: got data=%h first=%b last=%b err=%b, expected no beat",
                 got.data, got.first, got.last, got.error);
      end else begin
        exp = sb.pop_front();
        if (got !== exp) begin
          n_mismatch = n_mismatch + 1;
          $display("[TB] FAIL beat: got data=%h first=%b last=%b err=%b, expected data=%h first=%b last=%b err=%b",
                   got.data, got.first, got.last, got.error,
                   exp.data, exp.first, exp.last, exp.error);
        end
      end
    end
  end

  function automatic beat_t mk(input logic [7:0] d, input logic f, input logic l, input logic e);
    beat_t b;
    b.data  = d;
    b.first = f;
    b.last  = l;
    b.error = e;
    return b;
  endfunction

  // One unit per call; inputs change 1 time unit after the rising edge.
  task automatic send(input logic [7:0] d, input logic dv, input logic er);
    gmii_rxd   = d;
    gmii_rx_dv = dv;
    gmii_rx_er = er;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) send(8'h00, 1'b0, 1'b0);
  endtask

  task automatic gmii_pre(input int n);
    repeat (n) send(8'h55, 1'b1, 1'b0);
    send(8'hD5, 1'b1, 1'b0);
  endtask

  // Upper nibble carries junk to show MII ignores bits [7:4].
  task automatic mii_pre(input int n);
    repeat (n) send(8'hA5, 1'b1, 1'b0);
    send(8'hAD, 1'b1, 1'b0);
  endtask

  task automatic test_reset;
    rst        = 1'b1;
    gmii_rxd   = 8'h00;
    gmii_rx_dv = 1'b0;
    gmii_rx_er = 1'b0;
    mii_select = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_compared = n_compared + 6;
    if (mif.m_valid !== 1'b0) begin n_mismatch++; $display("[TB] FAIL reset_m_valid: got %b, expected 0", mif.m_valid); end
    if (mif.m_first !== 1'b0) begin n_mismatch++; $display("[TB] FAIL reset_m_first: got %b, expected 0", mif.m_first); end
    if (mif.m_last !== 1'b0)  begin n_mismatch++; $display("[TB] FAIL reset_m_last: got %b, expected 0", mif.m_last); end
    if (mif.m_error !== 1'b0) begin n_mismatch++; $display("[TB] FAIL reset_m_error: got %b, expected 0", mif.m_error); end
    if (mif.m_data !== 8'h00) begin n_mismatch++; $display("[TB] FAIL reset_m_data: got %h, expected 00", mif.m_data); end
    if (stat_bad_preamble !== 1'b0) begin n_mismatch++; $display("[TB] FAIL reset_stat: got %b, expected 0", stat_bad_preamble); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_gmii_basic;
    int st0;
    int e01;
    int e04;
    st0 = stat_cnt;
    sb.push_back(mk(8'h01, 1'b1, 1'b0, 1'b0));
    sb.push_back(mk(8'h02, 1'b0, 1'b0, 1'b0));
    sb.push_back(mk(8'h03, 1'b0, 1'b0, 1'b0));
    sb.push_back(mk(8'h04, 1'b0, 1'b1, 1'b0));
    gmii_pre(7);
    send(8'h01, 1'b1, 1'b0); e01 = cyc;
    send(8'h02, 1'b1, 1'b0);
    send(8'h03, 1'b1, 1'b0);
    send(8'h04, 1'b1, 1'b0); e04 = cyc;
    idle(4);
    n_compared = n_compared + 4;
    if (first_cyc !== e01 + 1) begin n_mismatch++; $display("[TB] FAIL gmii_first_latency: got cycle %0d, expected %0d", first_cyc, e01 + 1); end
    if (last_cyc !== e04 + 1)  begin n_mismatch++; $display("[TB] FAIL gmii_last_latency: got cycle %0d, expected %0d", last_cyc, e04 + 1); end
    if (sb.size() !== 0) begin n_mismatch++; $display("[TB] FAIL gmii_drain: got %0d beats pending, expected 0", sb.size()); sb.delete(); end
    if (stat_cnt !== st0) begin n_mismatch++; $display("[TB] FAIL gmii_stat: got %0d pulses, expected 0", stat_cnt - st0); end
  endtask

  task automatic test_mii;
    int e_hi;
    int e_b;
    mii_select = 1'b1;
    sb.push_back(mk(8'h01, 1'b1, 1'b0, 1'b0));
    sb.push_back(mk(8'h02, 1'b0, 1'b0, 1'b0));
    sb.push_back(mk(8'hBA, 1'b0, 1'b1, 1'b0));
    mii_pre(15);
    send(8'hF1, 1'b1, 1'b0);
    send(8'hF0, 1'b1, 1'b0); e_hi = cyc;
    send(8'hF2, 1'b1, 1'b0);
    send(8'hF0, 1'b1, 1'b0);
    send(8'hFA, 1'b1, 1'b0);
    send(8'hFB, 1'b1, 1'b0); e_b = cyc;
    idle(4);
    n_compared = n_compared + 3;
    if (first_cyc !== e_hi + 2) begin n_mismatch++; $display("[TB] FAIL mii_first_latency: got cycle %0d, expected %0d", first_cyc, e_hi + 2); end
    if (last_cyc !== e_b + 1)   begin n_mismatch++; $display("[TB] FAIL mii_last_latency: got cycle %0d, expected %0d", last_cyc, e_b + 1); end
    if (sb.size() !== 0) begin n_mismatch++; $display("[TB] FAIL mii_drain: got %0d beats pending, expected 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_mii_odd;
    mii_select = 1'b1;
    sb.push_back(mk(8'h01, 1'b1, 1'b1, 1'b1));
    mii_pre(15);
    // Dropping mii_select mid-frame must not change how this frame is decoded.
    mii_select = 1'b0;
    send(8'h31, 1'b1, 1'b0);
    send(8'h20, 1'b1, 1'b0);
    send(8'h17, 1'b1, 1'b0);
    idle(4);
    n_compared = n_compared + 1;
    if (sb.size() !== 0) begin n_mismatch++; $display("[TB] FAIL mii_odd_drain: got %0d beats pending, expected 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_error_and_bad_preamble;
    int st0;
    int e_bad;
    mii_select = 1'b0;
    st0 = stat_cnt;
    sb.push_back(mk(8'hA1, 1'b1, 1'b0, 1'b0));
    sb.push_back(mk(8'hA2, 1'b0, 1'b0, 1'b0));
    sb.push_back(mk(8'hA3, 1'b0, 1'b1, 1'b1));
    gmii_pre(7);
    send(8'hA1, 1'b1, 1'b0);
    send(8'hA2, 1'b1, 1'b1);
    send(8'hA3, 1'b1, 1'b0);
    idle(1);
    send(8'h55, 1'b1, 1'b0);
    send(8'h12, 1'b1, 1'b0); e_bad = cyc;
    send(8'h34, 1'b1, 1'b0);
    send(8'hD5, 1'b1, 1'b0);
    idle(4);
    n_compared = n_compared + 3;
    if (stat_cnt - st0 !== 1) begin n_mismatch++; $display("[TB] FAIL badpre_stat_count: got %0d pulses, expected 1", stat_cnt - st0); end
    if (stat_cyc !== e_bad)   begin n_mismatch++; $display("[TB] FAIL badpre_stat_cycle: got cycle %0d, expected %0d", stat_cyc, e_bad); end
    if (sb.size() !== 0) begin n_mismatch++; $display("[TB] FAIL err_drain: got %0d beats pending, expected 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_max_preamble;
    int st0;
    st0 = stat_cnt;
    sb.push_back(mk(8'h31, 1'b1, 1'b0, 1'b0));
    sb.push_back(mk(8'h32, 1'b0, 1'b1, 1'b0));
    gmii_pre(16);
    send(8'h11, 1'b1, 1'b0);
    send(8'h22, 1'b1, 1'b0);
    idle(1);
    // Exactly the limit is still accepted, straight after a one-cycle gap.
    gmii_pre(15);
    send(8'h31, 1'b1, 1'b0);
    send(8'h32, 1'b1, 1'b0);
    idle(4);
    n_compared = n_compared + 2;
    if (stat_cnt - st0 !== 1) begin n_mismatch++; $display("[TB] FAIL maxpre_stat_count: got %0d pulses, expected 1", stat_cnt - st0); end
    if (sb.size() !== 0) begin n_mismatch++; $display("[TB] FAIL maxpre_drain: got %0d beats pending, expected 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_back_to_back;
    int st0;
    st0 = stat_cnt;
    sb.push_back(mk(8'h77, 1'b1, 1'b1, 1'b0));
    sb.push_back(mk(8'h88, 1'b1, 1'b0, 1'b0));
    sb.push_back(mk(8'h99, 1'b0, 1'b1, 1'b0));
    gmii_pre(7);
    idle(1);
    send(8'hD5, 1'b1, 1'b0);
    send(8'h77, 1'b1, 1'b0);
    idle(1);
    send(8'h55, 1'b1, 1'b0);
    send(8'hD5, 1'b1, 1'b0);
    send(8'h88, 1'b1, 1'b0);
    send(8'h99, 1'b1, 1'b0);
    idle(4);
    n_compared = n_compared + 2;
    if (stat_cnt !== st0) begin n_mismatch++; $display("[TB] FAIL b2b_stat: got %0d pulses, expected 0", stat_cnt - st0); end
    if (sb.size() !== 0) begin n_mismatch++; $display("[TB] FAIL b2b_drain: got %0d beats pending, expected 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_reset_mid_frame;
    int st0;
    int e04;
    st0 = stat_cnt;
    sb.push_back(mk(8'h01, 1'b1, 1'b0, 1'b0));
    gmii_pre(7);
    send(8'h01, 1'b1, 1'b0);
    send(8'h02, 1'b1, 1'b0);
    rst = 1'b1;
    send(8'h03, 1'b1, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    n_compared = n_compared + 3;
    if (mif.m_valid !== 1'b0) begin n_mismatch++; $display("[TB] FAIL midrst_valid: got %b, expected 0", mif.m_valid); end
    if (mif.m_data !== 8'h00) begin n_mismatch++; $display("[TB] FAIL midrst_data: got %h, expected 00", mif.m_data); end
    if (mif.m_last !== 1'b0)  begin n_mismatch++; $display("[TB] FAIL midrst_last: got %b, expected 0", mif.m_last); end
    send(8'h04, 1'b1, 1'b0); e04 = cyc;
    send(8'h05, 1'b1, 1'b0);
    idle(2);
    sb.push_back(mk(8'hC1, 1'b1, 1'b0, 1'b0));
    sb.push_back(mk(8'hC2, 1'b0, 1'b1, 1'b0));
    gmii_pre(7);
    send(8'hC1, 1'b1, 1'b0);
    send(8'hC2, 1'b1, 1'b0);
    idle(4);
    n_compared = n_compared + 3;
    if (stat_cnt - st0 !== 1) begin n_mismatch++; $display("[TB] FAIL midrst_stat_count: got %0d pulses, expected 1", stat_cnt - st0); end
    if (stat_cyc !== e04)     begin n_mismatch++; $display("[TB] FAIL midrst_stat_cycle: got cycle %0d, expected %0d", stat_cyc, e04); end
    if (sb.size() !== 0) begin n_mismatch++; $display("[TB] FAIL midrst_drain: got %0d beats pending, expected 0", sb.size()); sb.delete(); end
  endtask

  initial begin
    test_reset();
    test_gmii_basic();
    test_mii();
    test_mii_odd();
    test_error_and_bad_preamble();
    test_max_preamble();
    test_back_to_back();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion by time %0t, expected completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
